// File: rtl/h75_pkg.sv
// h75_pkg: shared widths, bit-plane limits and swap-state type for the HUB75 pixel shifter.
package h75_pkg;
    localparam int ADDR_W    = 14;
    localparam int PIXEL_W   = 24;
    localparam int CHAN_W    = 8;
    localparam int MIN_PLANE = 2;
    localparam int MAX_PLANE = 7;

    typedef enum logic {IDLE, PENDING} swap_state_t;
endpackage

// File: rtl/h75_gamma_lut.sv
// h75_gamma_lut: combinational gamma-2.2 curve as a 17-knot piecewise-linear table over 16-code segments.
module h75_gamma_lut
    import h75_pkg::*;
(
    input  logic [CHAN_W-1:0] x,
    output logic [CHAN_W-1:0] y
);
    // Final knot sits past 255 so that code 255 interpolates to exactly 255.
    localparam logic [8:0] KNOT [17] = '{9'd0, 9'd1, 9'd3, 9'd6, 9'd12, 9'd20, 9'd30, 9'd42, 9'd56,
                                         9'd73, 9'd91, 9'd113, 9'd137, 9'd163, 9'd192, 9'd223, 9'd258};
    logic [8:0]  lo, hi;
    logic [12:0] step;

    always_comb begin
        lo   = KNOT[x[7:4]];
        hi   = KNOT[{1'b0, x[7:4]} + 5'd1];
        step = {4'b0, hi - lo} * {9'b0, x[3:0]};
        y    = 8'(lo + {4'b0, step[12:4]});
    end
endmodule

// File: rtl/h75_pixel_shifter.sv
// h75_pixel_shifter: double-buffered frame RAM addressing, bit-plane extraction and bank swap on frame sync.
// Define H75_GAMMA_EN to pass every colour channel through h75_gamma_lut before bit extraction.
module h75_pixel_shifter
    import h75_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_sync,
    input  logic [2:0]             plane,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_valid,
    output logic [ADDR_W:0]        ram_rd_addr,
    input  logic [2*PIXEL_W-1:0]   ram_rd_data,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [2*PIXEL_W-1:0]   wr_data,
    output logic                   ram_wr_en,
    output logic [ADDR_W:0]        ram_wr_addr,
    output logic [2*PIXEL_W-1:0]   ram_wr_data,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic                   bank,
    output logic                   r1,
    output logic                   g1,
    output logic                   b1,
    output logic                   r2,
    output logic                   g2,
    output logic                   b2
);
    swap_state_t       state, state_next;
    logic              armed, do_swap, fs_prev, fs_rise, valid_d;
    logic [2:0]        plane_d;
    logic [5:0]        pix, pix_next;
    logic [CHAN_W-1:0] chan [6];

    assign ram_rd_addr = {bank, rd_addr};
    assign ram_wr_en   = wr_en;
    assign ram_wr_addr = {~bank, wr_addr};
    assign ram_wr_data = wr_data;
    assign fs_rise     = frame_sync & ~fs_prev;
    assign {r1, g1, b1, r2, g2, b2} = pix;

    // chan[5] is top red down to chan[0] bottom blue, matching the RAM word layout.
    genvar i;
    for (i = 0; i < 6; i++) begin : g_chan
`ifdef H75_GAMMA_EN
        h75_gamma_lut u_lut (
            .x(ram_rd_data[CHAN_W*i +: CHAN_W]),
            .y(chan[i])
        );
`else
        assign chan[i] = ram_rd_data[CHAN_W*i +: CHAN_W];
`endif
    end

    always_comb begin
        pix_next = '0;
        for (int k = 0; k < 6; k++)
            pix_next[k] = plane_d >= 3'(MIN_PLANE) && chan[k][plane_d];
    end

    // A request seen on the same cycle as the sync edge swaps immediately.
    always_comb begin
        armed      = state == PENDING || swap_req;
        do_swap    = armed && fs_rise;
        state_next = armed && !fs_rise ? PENDING : IDLE;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            fs_prev  <= 1'b0;
            bank     <= 1'b0;
            swap_ack <= 1'b0;
            plane_d  <= '0;
            valid_d  <= 1'b0;
            pix      <= '0;
        end else begin
            fs_prev  <= frame_sync;
            bank     <= bank ^ do_swap;
            swap_ack <= do_swap;
            plane_d  <= plane;
            valid_d  <= rd_valid;
            if (valid_d)
                pix <= pix_next;
        end
endmodule

// File: tb/tb_h75_pixel_shifter.sv
// tb_h75_pixel_shifter: scoreboard bench for bit-plane output, write pass-through and bank swapping.
module tb_h75_pixel_shifter;
    typedef struct {
        int         due;
        logic [5:0] pix;
    } exp_t;

`ifdef H75_GAMMA_EN
    localparam logic GAMMA_R1 = 1'b1;
`else
    localparam logic GAMMA_R1 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, frame_sync, rd_valid, wr_en, swap_req;
    logic [2:0]  plane;
    logic [13:0] rd_addr, wr_addr;
    logic [47:0] ram_rd_data, wr_data, ram_wr_data;
    logic [14:0] ram_rd_addr, ram_wr_addr;
    logic        ram_wr_en, swap_ack, bank, r1, g1, b1, r2, g2, b2;
    logic [5:0]  pix_obs;

    int          errors = 0;
    int          checks = 0;
    logic        exp_bank;
    logic [5:0]  exp_pix;
    exp_t        sb[$];
    logic [47:0] mem [logic [14:0]];
    logic [7:0]  byte_set [4] = '{8'h00, 8'h01, 8'h80, 8'hFF};

    h75_pixel_shifter dut (
        .clk(clk), .resetn(resetn), .frame_sync(frame_sync), .plane(plane),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .bank(bank),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2)
    );

    always #10 clk = ~clk;
    assign pix_obs = {r1, g1, b1, r2, g2, b2};

    // Registered-read frame RAM model.
    always @(posedge clk)
        ram_rd_data <= mem.exists(ram_rd_addr) ? mem[ram_rd_addr] : 48'h0;

    function automatic logic [47:0] mem_val(input logic [14:0] a);
        return mem.exists(a) ? mem[a] : 48'h0;
    endfunction

    // Bench data only uses codes 00/01/80/FF, whose gamma-2.2 values are 0/0/56/255.
    function automatic logic [7:0] gam(input logic [7:0] v);
`ifdef H75_GAMMA_EN
        return v == 8'h80 ? 8'd56 : v == 8'h01 ? 8'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [5:0] pix_of(input logic [47:0] d, input logic [2:0] p);
        logic [5:0] r;
        logic [7:0] c;
        r = '0;
        if (p >= 3'd2)
            for (int k = 0; k < 6; k++) begin
                c = gam(d[8*k +: 8]);
                r[k] = c[p];
            end
        return r;
    endfunction

    function automatic logic [47:0] rand_word();
        logic [47:0] w;
        for (int k = 0; k < 6; k++)
            w[8*k +: 8] = byte_set[$urandom_range(0, 3)];
        return w;
    endfunction

    task automatic test_reset();
        resetn = 1'b0; frame_sync = 1'b0; plane = '0; rd_addr = '0; rd_valid = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %b want 0", bank); end
        if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", swap_ack); end
        if (pix_obs !== 6'b0) begin errors++; $display("FAIL reset_pix got %b want 000000", pix_obs); end
        if (ram_wr_addr !== 15'h4000) begin errors++; $display("FAIL reset_wr_addr got %h want 4000", ram_wr_addr); end
        resetn = 1'b1;
        exp_bank = 1'b0;
        exp_pix = '0;
    endtask

    task automatic test_pixel();
        logic [13:0] ta [7] = '{14'h25, 14'h25, 14'h100, 14'h3, 14'h25, 14'h25, 14'h25};
        logic [2:0]  tp [7] = '{3'd7, 3'd2, 3'd5, 3'd3, 3'd1, 3'd7, 3'd7};
        logic        tv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        mem[{1'b0, 14'h25}] = 48'h80_00_FF_01_80_00;
        mem[{1'b1, 14'h25}] = 48'h00_FF_00_80_01_FF;
        mem[{1'b0, 14'h100}] = 48'hFF_FF_FF_FF_FF_FF;
        sb.delete();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == i) begin
                e = sb.pop_front();
                checks++;
                if (pix_obs !== e.pix) begin errors++; $display("FAIL pixel@%0d got %b want %b", i, pix_obs, e.pix); end
            end
            if (i < 7) begin
                rd_addr = ta[i]; plane = tp[i]; rd_valid = tv[i];
                if (rd_valid) exp_pix = pix_of(mem_val({exp_bank, rd_addr}), plane);
                sb.push_back('{i + 2, exp_pix});
                #1;
                checks++;
                if (ram_rd_addr !== {exp_bank, rd_addr}) begin errors++; $display("FAIL rd_addr@%0d got %h want %h", i, ram_rd_addr, {exp_bank, rd_addr}); end
            end else rd_valid = 1'b0;
        end
    endtask

    task automatic test_swap();
        logic [63:0] req_m [3] = '{64'h400, 64'h5420, 64'h1F_FFFF};
        logic [63:0] fs_m  [3] = '{64'h007C_0000_0000_0000, 64'h0210_0020, 64'h120};
        logic [63:0] ack_m [3] = '{64'h0008_0000_0000_0000, 64'h0020_0040, 64'h240};
        wr_en = 1'b1; wr_addr = 14'h1234; wr_data = 48'hDEAD_BEEF_0123;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (ack_m[s][i]) exp_bank = ~exp_bank;
                checks += 3;
                if (bank !== exp_bank) begin errors++; $display("FAIL swap_bank s%0d@%0d got %b want %b", s, i, bank, exp_bank); end
                if (swap_ack !== ack_m[s][i]) begin errors++; $display("FAIL swap_ack s%0d@%0d got %b want %b", s, i, swap_ack, ack_m[s][i]); end
                if (ram_wr_addr !== {~exp_bank, wr_addr} || ram_wr_en !== 1'b1 || ram_wr_data !== wr_data) begin
                    errors++;
                    $display("FAIL wr_pass s%0d@%0d got en=%b addr=%h data=%h want addr=%h", s, i, ram_wr_en, ram_wr_addr, ram_wr_data, {~exp_bank, wr_addr});
                end
                swap_req = req_m[s][i];
                frame_sync = fs_m[s][i];
            end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] addrs [4] = '{14'h0, 14'h25, 14'h100, 14'h3FFF};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            mem[{1'b0, addrs[k]}] = rand_word();
            mem[{1'b1, addrs[k]}] = rand_word();
        end
        sb.delete();
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == i) begin
                e = sb.pop_front();
                checks++;
                if (pix_obs !== e.pix) begin errors++; $display("FAIL b2b@%0d got %b want %b", i, pix_obs, e.pix); end
            end
            if (i < 40) begin
                rd_addr = addrs[$urandom_range(0, 3)];
                plane = 3'($urandom_range(0, 7));
                rd_valid = $urandom_range(0, 3) != 0;
                if (rd_valid) exp_pix = pix_of(mem_val({exp_bank, rd_addr}), plane);
                sb.push_back('{i + 2, exp_pix});
            end else rd_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_swap();
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0;
        #3 resetn = 1'b0;
        #1;
        checks += 3;
        if (bank !== 1'b0) begin errors++; $display("FAIL mid_reset_bank got %b want 0", bank); end
        if (swap_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_ack got %b want 0", swap_ack); end
        if (pix_obs !== 6'b0) begin errors++; $display("FAIL mid_reset_pix got %b want 000000", pix_obs); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_bank = 1'b0;
        exp_pix = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 2;
            if (bank !== 1'b0) begin errors++; $display("FAIL no_swap_bank@%0d got %b want 0", i, bank); end
            if (swap_ack !== 1'b0) begin errors++; $display("FAIL no_swap_ack@%0d got %b want 0", i, swap_ack); end
            frame_sync = i == 3 || i == 4;
        end
    endtask

    task automatic test_gamma();
        exp_t e;
        mem[{1'b0, 14'h0100}] = 48'h80_00_00_00_00_00;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == i) begin
                e = sb.pop_front();
                checks++;
                if (pix_obs !== e.pix) begin errors++; $display("FAIL gamma_r1 got %b want %b", pix_obs, e.pix); end
            end
            if (i == 0) begin
                rd_addr = 14'h0100; plane = 3'd5; rd_valid = 1'b1;
                exp_pix = {GAMMA_R1, 5'b0};
                sb.push_back('{i + 2, exp_pix});
            end else rd_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_swap();
        test_back_to_back();
        test_reset_mid_swap();
        test_gamma();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/h75_pixel_shifter.md
H75_PIXEL_SHIFTER -- requirements
Module: h75_pixel_shifter

Interface
REQ-001 The block SHALL use reset resetn, asynchronous, active-low, and clock clk.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  system clock, 20 ns
- resetn  in  1  async active-low reset
- frame_sync  in  1  frame start pulse from timing generator
- plane  in  3  current bit plane, 7..2
- rd_addr  in  14  {row[4:0], x[8:0]} from timing generator
- rd_valid  in  1  timing generator data-valid strobe
- ram_rd_addr  out  15  {bank, rd_addr} to frame RAM read port
- ram_rd_data  in  48  [47:24] top pixel {R,G,B}, [23:0] bottom pixel {R,G,B}, 8 b per channel
- wr_en  in  1  host pixel write strobe
- wr_addr  in  14  host pixel address
- wr_data  in  48  host pixel pair
- ram_wr_en  out  1  frame RAM write strobe
- ram_wr_addr  out  15  {~bank, wr_addr}
- ram_wr_data  out  48  write data
- swap_req  in  1  host request to swap banks, pulse or level
- swap_ack  out  1  one-cycle pulse when swap takes effect
- bank  out  1  bank currently displayed
- r1, g1, b1, r2, g2, b2  out  1 each  panel colour data lines

Function
REQ-003 ram_rd_addr SHALL be combinational {bank, rd_addr}; the frame RAM returns ram_rd_data one cycle later (registered read).
REQ-004 plane and rd_valid SHALL be delayed one cycle (plane_d, valid_d) to align with ram_rd_data.
REQ-005 When valid_d=1, r1..b2 SHALL register bit plane_d of each channel: r1=data[40+p], g1=data[32+p], b1=data[24+p], r2=data[16+p], g2=data[8+p], b2=data[p].
REQ-006 When valid_d=0, r1..b2 SHALL hold their last value.
REQ-007 Latency rd_addr -> r1..b2 SHALL be exactly 2 cycles.
REQ-008 plane_d values 0 or 1 SHALL drive all colour outputs 0.
REQ-009 Host writes SHALL pass through in the same cycle: ram_wr_en=wr_en, ram_wr_addr={~bank, wr_addr}, ram_wr_data=wr_data; the displayed bank SHALL never be written.
REQ-010 The swap FSM SHALL have states IDLE, PENDING: IDLE -> PENDING on swap_req=1; PENDING -> IDLE on frame_sync rising edge, toggling bank and pulsing swap_ack for one cycle.
REQ-011 swap_req=1 in the same cycle as a frame_sync rising edge SHALL swap on that edge.
REQ-012 Additional swap_req while PENDING SHALL be absorbed (one swap only); swap_req held high SHALL re-arm PENDING the cycle after swap_ack.
REQ-013 Bank toggle SHALL take effect on ram_rd_addr and ram_wr_addr the cycle after the edge.
REQ-014 frame_sync edge detection SHALL use a registered previous value (reset 0).

Reset
REQ-015 On resetn=0: bank=0, swap_ack=0, FSM=IDLE, r1..b2=0, valid_d=0, plane_d=0, frame_sync history=0.
REQ-016 Reset mid-swap SHALL discard the pending request.

Configuration
REQ-017 With H75_GAMMA_EN defined, each 8-bit channel SHALL pass through a fixed gamma-2.2 LUT (0->0, 255->255, 128->56) before bit extraction, latency unchanged; without it, channels SHALL be used raw.

Structure
REQ-018 Package h75_pkg SHALL hold ADDR_W=14, PIXEL_W=24, CHAN_W=8, MIN_PLANE=2, MAX_PLANE=7 and the swap-state typedef.
REQ-019 The gamma table SHALL be sub-module h75_gamma_lut (8 b in, 8 b out, combinational), instantiated six times only under H75_GAMMA_EN.

Verification
REQ-020 rd_addr=0x0025, valid, plane=7, ram_rd_data=0x80_00_FF_01_80_00 -> two cycles later r1=1,g1=0,b1=1,r2=0,g2=1,b2=0.
REQ-021 Same data, plane=2 -> r1=0,g1=0,b1=1,r2=0,g2=0,b2=0; rd_valid then 0 -> outputs hold.
REQ-022 swap_req pulse at cycle 10, frame_sync rise at cycle 50 -> bank 0->1 at cycle 51, swap_ack high cycle 51 only; ram_wr_addr MSB becomes 0.
REQ-023 swap_req coincident with frame_sync rise -> swap on that edge; three swap_req pulses before one edge -> one toggle.
REQ-024 resetn low while PENDING -> bank=0, no swap on next frame_sync.
REQ-025 H75_GAMMA_EN defined, top R=128, plane=5 -> r1=1 (56=0b00111000); undefined -> r1=0.
